// File: rtl/mem_ctrl_pkg.sv
// Shared types for the byte-wide RAM controller: FSM state encoding, transfer
// size codes and the size-to-byte-count helper.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Code 11 is not a legal size; it is served as a full word.
  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bundle of the IF/MEM requester ports, the RAM port and the FSM debug state.
// master = pipeline plus RAM side, slave = the controller.
interface mem_ctrl_if #(parameter int ADDR_W = 17);
  import mem_ctrl_pkg::*;

  // Handshake: a requester raises req with stable fields and holds it until
  // its done pulses for one cycle; stallreq is req & ~done. A req still high
  // in the done cycle is not taken again.
  logic              if_req;
  logic [31:0]       if_addr;
  logic [31:0]       if_data;
  logic              if_done;
  logic              if_stallreq;

  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_done;
  logic              mem_stallreq;

  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_dout;
  logic              ram_wr;
  logic [7:0]        ram_din;

  state_t            state;

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
    input  if_data, if_done, if_stallreq, mem_rdata, mem_done, mem_stallreq,
           ram_a, ram_dout, ram_wr, state
  );

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
    output if_data, if_done, if_stallreq, mem_rdata, mem_done, mem_stallreq,
           ram_a, ram_dout, ram_wr, state
  );

endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates IF fetch and MEM load/store onto one byte-wide synchronous RAM,
// little-endian, one byte per cycle. Define PREEMPT_IF_EN to let MEM abort a fetch.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);

  state_t            state_q;
  logic [2:0]        cnt;
  logic              own_mem;
  logic [ADDR_W-1:0] base;
  logic [2:0]        n_bytes;
  logic [31:0]       wdata_q;
  logic [31:0]       asm_q;

  logic [ADDR_W-1:0] ram_a_q;
  logic [7:0]        ram_dout_q;
  logic              ram_wr_q;
  logic [31:0]       if_data_q;
  logic [31:0]       mem_rdata_q;
  logic              if_done_q;
  logic              mem_done_q;

  logic [ADDR_W-1:0] acc_addr;
  logic [2:0]        acc_n;
  logic [ADDR_W-1:0] addr_k;
  logic [7:0]        wbyte;
  logic [1:0]        byte_idx;
  logic [31:0]       asm_next;
  logic              preempt;
  logic              unused_addr_hi;

  // MEM has priority when both requesters are waiting.
  assign acc_addr = bus.mem_req ? bus.mem_addr[ADDR_W-1:0] : bus.if_addr[ADDR_W-1:0];
  assign acc_n    = bus.mem_req ? size_to_n(bus.mem_size) : 3'd4;
  assign addr_k   = base + ADDR_W'(cnt);
  assign wbyte    = wdata_q[{cnt[1:0], 3'b000} +: 8];

  // Byte k arrives on ram_din two edges after its address was driven.
  assign byte_idx = 2'(cnt - 3'd2);

  always_comb begin
    asm_next = asm_q;
    asm_next[{byte_idx, 3'b000} +: 8] = bus.ram_din;
  end

`ifdef PREEMPT_IF_EN
  assign preempt = (state_q == ST_RD) && !own_mem && bus.mem_req;
`else
  assign preempt = 1'b0;
`endif

  assign unused_addr_hi = ^{bus.if_addr[31:ADDR_W], bus.mem_addr[31:ADDR_W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt         <= 3'd0;
      own_mem     <= 1'b0;
      base        <= '0;
      n_bytes     <= 3'd0;
      wdata_q     <= 32'd0;
      asm_q       <= 32'd0;
      ram_a_q     <= '0;
      ram_dout_q  <= 8'd0;
      ram_wr_q    <= 1'b0;
      if_data_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          ram_wr_q <= 1'b0;
          // The done cycle blocks acceptance so a still-held req is not re-served.
          if (!if_done_q && !mem_done_q && (bus.mem_req || bus.if_req)) begin
            own_mem <= bus.mem_req;
            base    <= acc_addr;
            ram_a_q <= acc_addr;
            n_bytes <= acc_n;
            wdata_q <= bus.mem_wdata;
            asm_q   <= 32'd0;
            cnt     <= 3'd1;
            if (bus.mem_req && bus.mem_we) begin
              state_q    <= ST_WR;
              ram_dout_q <= bus.mem_wdata[7:0];
              ram_wr_q   <= 1'b1;
            end else begin
              state_q <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (preempt) begin
            state_q <= ST_IDLE;
          end else begin
            if (cnt < n_bytes) ram_a_q <= addr_k;
            if (cnt >= 3'd2) asm_q <= asm_next;
            if (cnt == n_bytes + 3'd1) begin
              state_q <= ST_IDLE;
              if (own_mem) begin
                mem_rdata_q <= asm_next;
                mem_done_q  <= 1'b1;
              end else begin
                if_data_q <= asm_next;
                if_done_q <= 1'b1;
              end
            end
            cnt <= cnt + 3'd1;
          end
        end
        ST_WR: begin
          if (cnt < n_bytes) begin
            ram_a_q    <= addr_k;
            ram_dout_q <= wbyte;
            ram_wr_q   <= 1'b1;
          end else begin
            ram_wr_q   <= 1'b0;
            mem_done_q <= 1'b1;
            state_q    <= ST_IDLE;
          end
          cnt <= cnt + 3'd1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ram_a        = ram_a_q;
  assign bus.ram_dout     = ram_dout_q;
  assign bus.ram_wr       = ram_wr_q;
  assign bus.if_data      = if_data_q;
  assign bus.mem_rdata    = mem_rdata_q;
  assign bus.if_done      = if_done_q;
  assign bus.mem_done     = mem_done_q;
  assign bus.if_stallreq  = bus.if_req & ~if_done_q;
  assign bus.mem_stallreq = bus.mem_req & ~mem_done_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: fetch, store, loads with address wrap, arbitration,
// reset abort and fetch preemption, against a behavioural byte RAM.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int ADDR_W = 17;

  logic clk;
  logic rst;
  int   total;
  int   passed;
  int   failed;
  int   t_if;
  int   t_mem;
  bit   saw_wr;
  bit   stall_drop;

  logic [7:0] ram [0:(1<<ADDR_W)-1];

  mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  mem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    bus.ram_din <= ram[bus.ram_a];
    if (bus.ram_wr) ram[bus.ram_a] <= bus.ram_dout;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Runs until every request that is high now has completed, dropping each
  // req in its done cycle; reports the tick count at which each done pulsed.
  task automatic run(output int ti, output int tm);
    bit pend_if;
    bit pend_mem;
    int n;
    pend_if    = bus.if_req;
    pend_mem   = bus.mem_req;
    ti         = -1;
    tm         = -1;
    n          = 0;
    saw_wr     = 1'b0;
    stall_drop = 1'b0;
    while ((pend_if || pend_mem) && n < 40) begin
      tick;
      n++;
      if (bus.ram_wr) saw_wr = 1'b1;
      if (pend_if && !bus.if_done && !bus.if_stallreq) stall_drop = 1'b1;
      if (pend_mem && !bus.mem_done && !bus.mem_stallreq) stall_drop = 1'b1;
      if (pend_if && bus.if_done) begin
        ti = n;
        bus.if_req = 1'b0;
        pend_if = 1'b0;
      end
      if (pend_mem && bus.mem_done) begin
        tm = n;
        bus.mem_req = 1'b0;
        pend_mem = 1'b0;
      end
    end
  endtask

  initial begin
    total  = 0;
    passed = 0;
    failed = 0;
    rst = 1'b1;
    bus.if_req = 1'b0;  bus.if_addr = 32'd0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_size = SIZE_B;
    bus.mem_addr = 32'd0; bus.mem_wdata = 32'd0;

    ram[17'h00100] = 8'h11; ram[17'h00101] = 8'h22;
    ram[17'h00102] = 8'h33; ram[17'h00103] = 8'h44;
    ram[17'h00200] = 8'h00; ram[17'h00201] = 8'h00;
    ram[17'h00202] = 8'h5A; ram[17'h00203] = 8'h77;
    ram[17'h1FFFF] = 8'h80;
    ram[17'h00000] = 8'h9A; ram[17'h00001] = 8'hBC; ram[17'h00002] = 8'hDE;
    for (int i = 0; i < 4; i++) ram[17'h00300 + 17'(i)] = 8'hEE;

    tick;
    tick;
    check("rst_ram_a", 32'(bus.ram_a), 32'd0);
    check("rst_ram_dout", 32'(bus.ram_dout), 32'd0);
    check("rst_ram_wr", 32'(bus.ram_wr), 32'd0);
    check("rst_if_data", bus.if_data, 32'd0);
    check("rst_mem_rdata", bus.mem_rdata, 32'd0);
    check("rst_if_done", 32'(bus.if_done), 32'd0);
    check("rst_mem_done", 32'(bus.mem_done), 32'd0);
    check("rst_state", 32'(bus.state), 32'(ST_IDLE));
    rst = 1'b0;
    tick;

    // Word fetch: done at E5.
    bus.if_addr = 32'h0000_0100;
    bus.if_req  = 1'b1;
    run(t_if, t_mem);
    check("fetch_latency", t_if, 32'd6);
    check("fetch_data", bus.if_data, 32'h4433_2211);
    check("fetch_no_write", 32'(saw_wr), 32'd0);
    check("fetch_stall", 32'(stall_drop), 32'd0);
    tick;
    check("fetch_done_drop", 32'(bus.if_done), 32'd0);

    // Halfword store: done at E2, third byte untouched.
    bus.mem_we = 1'b1; bus.mem_size = SIZE_H;
    bus.mem_addr = 32'h0000_0200; bus.mem_wdata = 32'hAABB_CCDD;
    bus.mem_req = 1'b1;
    run(t_if, t_mem);
    bus.mem_we = 1'b0;
    check("store_latency", t_mem, 32'd3);
    check("store_b0", 32'(ram[17'h00200]), 32'h0000_00DD);
    check("store_b1", 32'(ram[17'h00201]), 32'h0000_00CC);
    check("store_b2_kept", 32'(ram[17'h00202]), 32'h0000_005A);
    check("store_wr_idle", 32'(bus.ram_wr), 32'd0);
    tick;

    // Byte load at the top address, then a word load that wraps.
    bus.mem_size = SIZE_B; bus.mem_addr = 32'h0001_FFFF; bus.mem_req = 1'b1;
    run(t_if, t_mem);
    check("ldb_latency", t_mem, 32'd3);
    check("ldb_data", bus.mem_rdata, 32'h0000_0080);
    bus.mem_size = SIZE_W; bus.mem_addr = 32'hFFFF_FFFF; bus.mem_req = 1'b1;
    check("done_cycle_stall", 32'(bus.mem_stallreq), 32'd0);
    tick;
    check("no_reaccept", 32'(bus.state), 32'(ST_IDLE));
    run(t_if, t_mem);
    check("ldw_wrap_latency", t_mem, 32'd6);
    check("ldw_wrap_data", bus.mem_rdata, 32'hDEBC_9A80);
    tick;

    // Simultaneous requests: MEM first, IF after the done cycle.
    bus.mem_size = SIZE_W; bus.mem_addr = 32'h0000_0200;
    bus.if_addr = 32'h0000_0100;
    bus.mem_req = 1'b1; bus.if_req = 1'b1;
    run(t_if, t_mem);
    check("arb_mem_time", t_mem, 32'd6);
    check("arb_if_time", t_if, 32'd13);
    check("arb_mem_data", bus.mem_rdata, 32'h775A_CCDD);
    check("arb_if_data", bus.if_data, 32'h4433_2211);
    check("arb_stall", 32'(stall_drop), 32'd0);
    check("arb_no_write", 32'(saw_wr), 32'd0);
    tick;

    // Reset at E2 of a word store: only bytes 0 and 1 land.
    bus.mem_we = 1'b1; bus.mem_size = SIZE_W;
    bus.mem_addr = 32'h0000_0300; bus.mem_wdata = 32'h4433_2211;
    bus.mem_req = 1'b1;
    tick;
    tick;
    rst = 1'b1;
    tick;
    check("rst_abort_wr", 32'(bus.ram_wr), 32'd0);
    check("rst_abort_state", 32'(bus.state), 32'(ST_IDLE));
    check("rst_abort_ram_a", 32'(bus.ram_a), 32'd0);
    check("rst_abort_rdata", bus.mem_rdata, 32'd0);
    rst = 1'b0; bus.mem_req = 1'b0; bus.mem_we = 1'b0;
    tick;
    check("rst_abort_b0", 32'(ram[17'h00300]), 32'h0000_0011);
    check("rst_abort_b1", 32'(ram[17'h00301]), 32'h0000_0022);
    check("rst_abort_b2", 32'(ram[17'h00302]), 32'h0000_00EE);
    check("rst_abort_b3", 32'(ram[17'h00303]), 32'h0000_00EE);

    // MEM request arriving at E2 of a fetch.
    bus.if_addr = 32'h0000_0100; bus.if_req = 1'b1;
    tick;
    tick;
    bus.mem_size = SIZE_B; bus.mem_addr = 32'h0000_0200; bus.mem_req = 1'b1;
    run(t_if, t_mem);
`ifdef PREEMPT_IF_EN
    check("pre_mem_time", t_mem, 32'd4);
    check("pre_if_time", t_if, 32'd11);
`else
    check("pre_if_time", t_if, 32'd4);
    check("pre_mem_time", t_mem, 32'd8);
`endif
    check("pre_if_data", bus.if_data, 32'h4433_2211);
    check("pre_mem_data", bus.mem_rdata, 32'h0000_00DD);
    check("pre_stall", 32'(stall_drop), 32'd0);
    tick;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
